core_sequencer: RTL and testbench

// Multi-cycle control FSM for the RV32I core. Fetches into an instruction register that drives the combinational

---
 rtl/core_pkg.sv | 32 +++
 rtl/seq_timeout_counter.sv | 30 +++
 rtl/core_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_core_sequencer.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencer: FSM states, fault causes,
// reset defaults and the PC advance helper.
package core_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_DECODE    = 3'd2,
      ST_EXECUTE   = 3'd3,
      ST_MEM       = 3'd4,
      ST_WRITEBACK = 3'd5,
      ST_HALT      = 3'd6
   } seq_state_t;

   typedef enum logic [2:0] {
      FLT_NONE         = 3'd0,
      FLT_ILLEGAL      = 3'd1,
      FLT_IMEM_TIMEOUT = 3'd2,
      FLT_DMEM_TIMEOUT = 3'd3,
      FLT_MISALIGNED   = 3'd4
   } fault_t;

   localparam logic [31:0] NOP_WORD         = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   function automatic logic [31:0] next_pc(input logic [31:0] pc,
                                           input logic        taken,
                                           input logic [31:0] target);
      return taken ? target : pc + 32'd4;
   endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// Memory-handshake watchdog: down-counter reloaded on clear, counts waiting cycles
// and flags expiry on the MEM_TIMEOUT-th cycle without an ack. MEM_TIMEOUT=0 disables it.
module seq_timeout_counter #(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic clk_sys,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         cnt_q <= LAST;
      end else if (clear) begin
         cnt_q <= LAST;
      end else if (enable && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CW'(1);
      end
   end

   assign expired = (MEM_TIMEOUT != 0) && enable && (cnt_q == '0);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the RV32I core: owns PC, instruction register, memory
// request handshakes, register-file write strobe, retired count and fault halting.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   IDLE      | stopped at an instruction boundary, waiting for Run
//   FETCH     | IMemReq held at PC until IMemAck; watchdog running
//   DECODE    | decoder settles on Instruction; illegal opcode halts
//   EXECUTE   | choose memory access, writeback or immediate retire
//   MEM       | DMemReq/DMemWrite held until DMemAck; watchdog running
//   WRITEBACK | one-cycle RegWriteEnable strobe, then retire
//   HALT      | sticky fault stop, cleared only by Reset
module core_sequencer
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
   parameter int          MEM_TIMEOUT = 255,
   parameter int          CNT_W       = 32
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Run,
   output logic             IMemReq,
   output logic [31:0]      IMemAddr,
   input  logic             IMemAck,
   input  logic [31:0]      IMemData,
   output logic [31:0]      Instruction,
   input  logic             WritesRegisterFile,
   input  logic             ReadsRam,
   input  logic             WritesRam,
   input  logic             InvalidInstructionSignal,
   input  logic             BranchTaken,
   input  logic [31:0]      BranchTarget,
   output logic             DMemReq,
   output logic             DMemWrite,
   input  logic             DMemAck,
   output logic             RegWriteEnable,
   output logic [31:0]      PC,
   output logic [2:0]       State,
   output logic             Halted,
   output logic [2:0]       Fault,
   output logic [CNT_W-1:0] InstRetired
);

   seq_state_t       state_q, state_n;
   fault_t           fault_q, fault_n, halt_code;
   logic [31:0]      pc_q, pc_n, instr_q, instr_n;
   logic [CNT_W-1:0] retired_q, retired_n;
   logic             imem_req_q, imem_req_n;
   logic             dmem_req_q, dmem_req_n;
   logic             dmem_write_q, dmem_write_n;
   logic             rwe_q, rwe_n;
   logic             halted_q, halted_n;
   logic             retire, halt;
   logic             tmr_clear, tmr_enable, tmr_expired;

   assign tmr_enable = (state_q == ST_FETCH) || (state_q == ST_MEM);
   assign tmr_clear  = ((state_n == ST_FETCH) || (state_n == ST_MEM)) && (state_n != state_q);

   seq_timeout_counter #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_timeout (
      .clk_sys (Clock),
      .rst     (Reset),
      .clear   (tmr_clear),
      .enable  (tmr_enable),
      .expired (tmr_expired)
   );

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q      <= ST_IDLE;
         fault_q      <= FLT_NONE;
         pc_q         <= RESET_PC;
         instr_q      <= NOP_WORD;
         retired_q    <= '0;
         imem_req_q   <= 1'b0;
         dmem_req_q   <= 1'b0;
         dmem_write_q <= 1'b0;
         rwe_q        <= 1'b0;
         halted_q     <= 1'b0;
      end else begin
         state_q      <= state_n;
         fault_q      <= fault_n;
         pc_q         <= pc_n;
         instr_q      <= instr_n;
         retired_q    <= retired_n;
         imem_req_q   <= imem_req_n;
         dmem_req_q   <= dmem_req_n;
         dmem_write_q <= dmem_write_n;
         rwe_q        <= rwe_n;
         halted_q     <= halted_n;
      end
   end

   always_comb begin
      state_n      = state_q;
      fault_n      = fault_q;
      pc_n         = pc_q;
      instr_n      = instr_q;
      retired_n    = retired_q;
      imem_req_n   = imem_req_q;
      dmem_req_n   = dmem_req_q;
      dmem_write_n = dmem_write_q;
      rwe_n        = 1'b0;
      halted_n     = halted_q;
      retire       = 1'b0;
      halt         = 1'b0;
      halt_code    = FLT_NONE;

      case (state_q)
         ST_IDLE: begin
            if (Run) begin
               state_n    = ST_FETCH;
               imem_req_n = 1'b1;
            end
         end
         ST_FETCH: begin
            // An ack on the final watchdog cycle still wins over the timeout.
            if (imem_req_q && IMemAck) begin
               instr_n    = IMemData;
               imem_req_n = 1'b0;
               state_n    = ST_DECODE;
            end else if (tmr_expired) begin
               halt      = 1'b1;
               halt_code = FLT_IMEM_TIMEOUT;
            end
         end
         ST_DECODE: begin
            if (InvalidInstructionSignal) begin
               halt      = 1'b1;
               halt_code = FLT_ILLEGAL;
            end else begin
               state_n = ST_EXECUTE;
            end
         end
         ST_EXECUTE: begin
            if (ReadsRam || WritesRam) begin
               state_n      = ST_MEM;
               dmem_req_n   = 1'b1;
               dmem_write_n = WritesRam;
            end else if (WritesRegisterFile) begin
               state_n = ST_WRITEBACK;
               rwe_n   = 1'b1;
            end else begin
               retire = 1'b1;
            end
         end
         ST_MEM: begin
            if (dmem_req_q && DMemAck) begin
               dmem_req_n   = 1'b0;
               dmem_write_n = 1'b0;
               if (WritesRegisterFile) begin
                  state_n = ST_WRITEBACK;
                  rwe_n   = 1'b1;
               end else begin
                  retire = 1'b1;
               end
            end else if (tmr_expired) begin
               halt      = 1'b1;
               halt_code = FLT_DMEM_TIMEOUT;
            end
         end
         ST_WRITEBACK: begin
            retire = 1'b1;
         end
         ST_HALT: begin
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase

      // A misaligned taken branch must not retire: PC and count stay put.
      if (retire) begin
         if (BranchTaken && (BranchTarget[1:0] != 2'b00)) begin
            halt      = 1'b1;
            halt_code = FLT_MISALIGNED;
         end else begin
            pc_n       = next_pc(pc_q, BranchTaken, BranchTarget);
            retired_n  = retired_q + CNT_W'(1);
            state_n    = Run ? ST_FETCH : ST_IDLE;
            imem_req_n = Run;
         end
      end

      if (halt) begin
         state_n      = ST_HALT;
         imem_req_n   = 1'b0;
         dmem_req_n   = 1'b0;
         dmem_write_n = 1'b0;
         rwe_n        = 1'b0;
         halted_n     = 1'b1;
         if (fault_q == FLT_NONE) begin
            fault_n = halt_code;
         end
      end
   end

   assign IMemReq        = imem_req_q;
   assign IMemAddr       = pc_q;
   assign Instruction    = instr_q;
   assign DMemReq        = dmem_req_q;
   assign DMemWrite      = dmem_write_q;
   assign RegWriteEnable = rwe_q;
   assign PC             = pc_q;
   assign State          = state_q;
   assign Halted         = halted_q;
   assign Fault          = fault_q;
   assign InstRetired    = retired_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: program memory with delayed-ack responders, an opcode
// decoder model, and a retire scoreboard holding expected PC / retired count.
module tb_core_sequencer;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        Run = 1'b0;
   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic        IMemAck = 1'b0;
   logic [31:0] IMemData;
   logic [31:0] Instruction;
   logic        WritesRegisterFile, ReadsRam, WritesRam, InvalidInstructionSignal;
   logic        BranchTaken = 1'b0;
   logic [31:0] BranchTarget = 32'h0;
   logic        DMemReq, DMemWrite;
   logic        DMemAck = 1'b0;
   logic        RegWriteEnable;
   logic [31:0] PC;
   logic [2:0]  State;
   logic        Halted;
   logic [2:0]  Fault;
   logic [31:0] InstRetired;

   core_sequencer #(
      .RESET_PC    (32'h0000_0000),
      .MEM_TIMEOUT (4),
      .CNT_W       (32)
   ) dut (
      .Clock                    (Clock),
      .Reset                    (Reset),
      .Run                      (Run),
      .IMemReq                  (IMemReq),
      .IMemAddr                 (IMemAddr),
      .IMemAck                  (IMemAck),
      .IMemData                 (IMemData),
      .Instruction              (Instruction),
      .WritesRegisterFile       (WritesRegisterFile),
      .ReadsRam                 (ReadsRam),
      .WritesRam                (WritesRam),
      .InvalidInstructionSignal (InvalidInstructionSignal),
      .BranchTaken              (BranchTaken),
      .BranchTarget             (BranchTarget),
      .DMemReq                  (DMemReq),
      .DMemWrite                (DMemWrite),
      .DMemAck                  (DMemAck),
      .RegWriteEnable           (RegWriteEnable),
      .PC                       (PC),
      .State                    (State),
      .Halted                   (Halted),
      .Fault                    (Fault),
      .InstRetired              (InstRetired)
   );

   always #5 Clock = ~Clock;

   int checks = 0;
   int failures = 0;

   logic [31:0] prog [0:63];
   assign IMemData = prog[IMemAddr[7:2]];

   always_comb begin
      WritesRegisterFile       = 1'b0;
      ReadsRam                 = 1'b0;
      WritesRam                = 1'b0;
      InvalidInstructionSignal = 1'b0;
      case (Instruction[6:0])
         7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67: WritesRegisterFile = 1'b1;
         7'h03: begin
            ReadsRam           = 1'b1;
            WritesRegisterFile = 1'b1;
         end
         7'h23: WritesRam = 1'b1;
         7'h63: begin
         end
         default: InvalidInstructionSignal = 1'b1;
      endcase
   end

   // Memory responders: ack once the request has been held for *_delay cycles.
   int imem_delay = 0, dmem_delay = 0, iwait = 0, dwait = 0;
   always @(negedge Clock) begin
      if (IMemReq) begin
         IMemAck = (iwait >= imem_delay);
         iwait++;
      end else begin
         IMemAck = 1'b0;
         iwait = 0;
      end
      if (DMemReq) begin
         DMemAck = (dwait >= dmem_delay);
         dwait++;
      end else begin
         DMemAck = 1'b0;
         dwait = 0;
      end
   end

   // Activity monitors sample the cycle that just ended.
   int   rwe_cnt = 0, dreq_cycles = 0, ireq_cycles = 0, ireq_rise = 0;
   bit   dwrite_seen = 0;
   logic ireq_prev = 1'b0;
   always @(posedge Clock) begin
      if (RegWriteEnable) rwe_cnt++;
      if (DMemReq) begin
         dreq_cycles++;
         if (DMemWrite) dwrite_seen = 1;
      end
      if (IMemReq) ireq_cycles++;
      if (IMemReq && !ireq_prev) ireq_rise++;
      ireq_prev = IMemReq;
   end

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] cnt;
   } sb_t;
   sb_t         sb_q[$];
   sb_t         sb_e;
   logic [31:0] last_ret = '0;
   logic [31:0] m_pc = '0;
   logic [31:0] m_cnt = '0;

   always @(posedge Clock) begin
      if (Reset) begin
         last_ret = '0;
      end else if (InstRetired !== last_ret) begin
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL sb_retire: unexpected retire, InstRetired=%0d PC=%h", InstRetired, PC);
         end else begin
            sb_e = sb_q.pop_front();
            if (PC !== sb_e.pc || InstRetired !== sb_e.cnt) begin
               failures++;
               $display("FAIL sb_retire: PC=%h InstRetired=%0d, expected PC=%h InstRetired=%0d",
                        PC, InstRetired, sb_e.pc, sb_e.cnt);
            end
         end
         last_ret = InstRetired;
      end
   end

   task automatic push_retire(input logic [31:0] new_pc);
      m_pc  = new_pc;
      m_cnt = m_cnt + 32'd1;
      sb_q.push_back('{pc: new_pc, cnt: m_cnt});
   endtask

   task automatic clear_mon();
      rwe_cnt     = 0;
      dreq_cycles = 0;
      ireq_cycles = 0;
      ireq_rise   = 0;
      dwrite_seen = 0;
   endtask

   task automatic apply_reset();
      Reset = 1'b1;
      Run   = 1'b0;
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
      m_pc  = '0;
      m_cnt = '0;
      @(negedge Clock);
   endtask

   // Launch one instruction from IDLE with Run dropped right after FETCH entry.
   task automatic step_one(output int cycles, output bit ok);
      Run = 1'b1;
      @(negedge Clock);
      Run = 1'b0;
      cycles = 0;
      ok = 0;
      for (int i = 0; i < 60; i++) begin
         if (State == 3'd0) begin
            ok = 1;
            break;
         end
         cycles++;
         @(negedge Clock);
      end
   endtask

   task automatic wait_halt(output bit ok);
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge Clock);
         if (Halted) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bit seen;
      Reset = 1'b1;
      Run   = 1'b0;
      repeat (2) @(negedge Clock);
      checks++; if (State !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", State); end
      checks++; if (PC !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h want 00000000", PC); end
      checks++; if (Instruction !== 32'h0000_0013) begin failures++; $display("FAIL reset_instr: got %h want 00000013", Instruction); end
      checks++; if ({IMemReq, DMemReq, RegWriteEnable, Halted} !== 4'b0) begin failures++; $display("FAIL reset_strobes: got %b want 0000", {IMemReq, DMemReq, RegWriteEnable, Halted}); end
      checks++; if (Fault !== 3'd0 || InstRetired !== 32'd0) begin failures++; $display("FAIL reset_fault_cnt: got %0d/%0d want 0/0", Fault, InstRetired); end
      Reset = 1'b0;
      repeat (2) @(negedge Clock);
      checks++; if (State !== 3'd0 || IMemReq !== 1'b0) begin failures++; $display("FAIL idle_no_run: state %0d req %b want 0 0", State, IMemReq); end

      imem_delay = 1000;
      Run = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge Clock);
         if (IMemReq) begin
            seen = 1;
            break;
         end
      end
      checks++; if (!seen) begin failures++; $display("FAIL fetch_start: IMemReq never rose, want 1"); end
      checks++; if (IMemAddr !== 32'h0) begin failures++; $display("FAIL fetch_addr: got %h want 00000000", IMemAddr); end
      Reset = 1'b1;
      #1;
      checks++; if (IMemReq !== 1'b0) begin failures++; $display("FAIL reset_drops_req: IMemReq got %b want 0", IMemReq); end
      checks++; if (State !== 3'd0 || PC !== 32'h0) begin failures++; $display("FAIL reset_mid: state %0d pc %h want 0 00000000", State, PC); end
      Run = 1'b0;
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
      imem_delay = 0;
      @(negedge Clock);
   endtask

   task automatic test_alu();
      int cyc;
      bit ok;
      prog[0] = 32'h0050_0093;
      push_retire(m_pc + 32'd4);
      clear_mon();
      step_one(cyc, ok);
      checks++; if (!ok || cyc != 4) begin failures++; $display("FAIL alu_cycles: got %0d (ok=%0b) want 4", cyc, ok); end
      checks++; if (rwe_cnt != 1) begin failures++; $display("FAIL alu_rwe: got %0d strobes want 1", rwe_cnt); end
      checks++; if (ireq_cycles != 1) begin failures++; $display("FAIL alu_ireq: got %0d cycles want 1", ireq_cycles); end
      checks++; if (Instruction !== 32'h0050_0093) begin failures++; $display("FAIL alu_instr: got %h want 00500093", Instruction); end
   endtask

   task automatic test_load();
      int cyc;
      bit ok;
      prog[1] = 32'h0000_A103;
      dmem_delay = 2;
      push_retire(m_pc + 32'd4);
      clear_mon();
      step_one(cyc, ok);
      checks++; if (!ok || cyc != 7) begin failures++; $display("FAIL load_cycles: got %0d (ok=%0b) want 7", cyc, ok); end
      checks++; if (dreq_cycles != 3) begin failures++; $display("FAIL load_dreq: got %0d cycles want 3", dreq_cycles); end
      checks++; if (dwrite_seen) begin failures++; $display("FAIL load_dwrite: got 1 want 0"); end
      checks++; if (rwe_cnt != 1) begin failures++; $display("FAIL load_rwe: got %0d strobes want 1", rwe_cnt); end
      dmem_delay = 0;
   endtask

   task automatic test_store();
      int cyc;
      bit ok;
      prog[2] = 32'h0020_A023;
      push_retire(m_pc + 32'd4);
      clear_mon();
      step_one(cyc, ok);
      checks++; if (!ok || cyc != 4) begin failures++; $display("FAIL store_cycles: got %0d (ok=%0b) want 4", cyc, ok); end
      checks++; if (!dwrite_seen || dreq_cycles != 1) begin failures++; $display("FAIL store_dmem: dwrite %0b dreq %0d want 1 1", dwrite_seen, dreq_cycles); end
      checks++; if (rwe_cnt != 0) begin failures++; $display("FAIL store_rwe: got %0d strobes want 0", rwe_cnt); end
      checks++; if (PC !== 32'd12) begin failures++; $display("FAIL store_pc: got %h want 0000000c", PC); end
   endtask

   task automatic test_back_to_back();
      int          cyc;
      bit          ok;
      logic [31:0] stop_cnt;
      prog[3] = 32'h0010_0113;
      prog[4] = 32'h0000_A183;
      prog[5] = 32'h0030_0213;
      push_retire(m_pc + 32'd4);
      stop_cnt = m_cnt;
      push_retire(m_pc + 32'd4);
      stop_cnt = m_cnt;
      push_retire(m_pc + 32'd4);
      clear_mon();
      Run = 1'b1;
      @(negedge Clock);
      cyc = 0;
      ok = 0;
      for (int i = 0; i < 80; i++) begin
         if (State == 3'd0) begin
            ok = 1;
            break;
         end
         cyc++;
         if (InstRetired == stop_cnt) Run = 1'b0;
         @(negedge Clock);
      end
      checks++; if (!ok || cyc != 13) begin failures++; $display("FAIL b2b_cycles: got %0d (ok=%0b) want 13", cyc, ok); end
      checks++; if (rwe_cnt != 3) begin failures++; $display("FAIL b2b_rwe: got %0d strobes want 3", rwe_cnt); end
      checks++; if (ireq_rise != 3) begin failures++; $display("FAIL b2b_fetches: got %0d want 3", ireq_rise); end
   endtask

   task automatic test_branch();
      int cyc;
      bit ok;
      prog[6]  = 32'h0000_0063;
      prog[63] = 32'h0070_0293;
      BranchTaken  = 1'b1;
      BranchTarget = 32'hFFFF_FFFC;
      push_retire(32'hFFFF_FFFC);
      clear_mon();
      step_one(cyc, ok);
      checks++; if (!ok || PC !== 32'hFFFF_FFFC) begin failures++; $display("FAIL branch_pc: got %h (ok=%0b) want fffffffc", PC, ok); end
      checks++; if (rwe_cnt != 0 || cyc != 3) begin failures++; $display("FAIL branch_flow: rwe %0d cycles %0d want 0 3", rwe_cnt, cyc); end
      BranchTaken = 1'b0;
      push_retire(m_pc + 32'd4);
      step_one(cyc, ok);
      checks++; if (!ok || PC !== 32'h0) begin failures++; $display("FAIL pc_wrap: got %h (ok=%0b) want 00000000", PC, ok); end
   endtask

   task automatic test_misaligned();
      bit ok;
      prog[0]      = 32'h0050_0093;
      BranchTaken  = 1'b1;
      BranchTarget = 32'h0000_0102;
      clear_mon();
      Run = 1'b1;
      wait_halt(ok);
      Run = 1'b0;
      checks++; if (!ok || Fault !== 3'd4) begin failures++; $display("FAIL misalign_fault: got %0d (halted=%0b) want 4", Fault, ok); end
      checks++; if (PC !== m_pc || InstRetired !== m_cnt) begin failures++; $display("FAIL misalign_hold: pc %h cnt %0d want %h %0d", PC, InstRetired, m_pc, m_cnt); end
      checks++; if (State !== 3'd6) begin failures++; $display("FAIL misalign_state: got %0d want 6", State); end
      BranchTaken = 1'b0;
   endtask

   task automatic test_illegal();
      bit ok;
      apply_reset();
      prog[0] = 32'hFFFF_FFFF;
      Run = 1'b1;
      wait_halt(ok);
      clear_mon();
      repeat (10) @(negedge Clock);
      checks++; if (!ok || Fault !== 3'd1) begin failures++; $display("FAIL illegal_fault: got %0d (halted=%0b) want 1", Fault, ok); end
      checks++; if (PC !== 32'h0 || InstRetired !== 32'd0) begin failures++; $display("FAIL illegal_hold: pc %h cnt %0d want 00000000 0", PC, InstRetired); end
      checks++; if (ireq_rise != 0 || IMemReq !== 1'b0) begin failures++; $display("FAIL illegal_no_fetch: rises %0d req %b want 0 0", ireq_rise, IMemReq); end
      checks++; if (Halted !== 1'b1 || State !== 3'd6) begin failures++; $display("FAIL illegal_sticky: halted %b state %0d want 1 6", Halted, State); end
      Run = 1'b0;
   endtask

   task automatic test_imem_timeout();
      bit ok;
      apply_reset();
      prog[0] = 32'h0050_0093;
      imem_delay = 1000;
      clear_mon();
      Run = 1'b1;
      wait_halt(ok);
      Run = 1'b0;
      checks++; if (!ok || Fault !== 3'd2) begin failures++; $display("FAIL imem_to_fault: got %0d (halted=%0b) want 2", Fault, ok); end
      checks++; if (ireq_cycles != 4) begin failures++; $display("FAIL imem_to_cycles: got %0d want 4", ireq_cycles); end
      checks++; if (IMemReq !== 1'b0 || PC !== 32'h0) begin failures++; $display("FAIL imem_to_outputs: req %b pc %h want 0 00000000", IMemReq, PC); end
      imem_delay = 0;
   endtask

   task automatic test_dmem_timeout();
      bit ok;
      apply_reset();
      prog[0] = 32'h0000_A103;
      dmem_delay = 1000;
      clear_mon();
      Run = 1'b1;
      wait_halt(ok);
      Run = 1'b0;
      checks++; if (!ok || Fault !== 3'd3) begin failures++; $display("FAIL dmem_to_fault: got %0d (halted=%0b) want 3", Fault, ok); end
      checks++; if (dreq_cycles != 4 || DMemReq !== 1'b0) begin failures++; $display("FAIL dmem_to_req: cycles %0d req %b want 4 0", dreq_cycles, DMemReq); end
      checks++; if (InstRetired !== 32'd0 || rwe_cnt != 0) begin failures++; $display("FAIL dmem_to_retire: cnt %0d rwe %0d want 0 0", InstRetired, rwe_cnt); end
      dmem_delay = 0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) prog[i] = 32'h0000_0013;
      test_reset();
      test_alu();
      test_load();
      test_store();
      test_back_to_back();
      test_branch();
      test_misaligned();
      test_illegal();
      test_imem_timeout();
      test_dmem_timeout();
      repeat (3) @(negedge Clock);
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL sb_drain: %0d expected retires never seen, want 0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
